// File: rtl/mux_nx1_rr_valid.sv
// N-to-1 valid-qualified word multiplexer with direct-select and round-robin modes.
// The output word, valid flag and source index are registered, and a saturating
// counter tracks how many words were accepted.
module mux_nx1_rr_valid #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS),
  parameter int unsigned CNT_W    = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic [SEL_W-1:0]            select,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  input  logic [CHANNELS-1:0]         in_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  output logic [SEL_W-1:0]            out_sel,
  output logic [CNT_W-1:0]            word_count
);

  // Valid vector padded to every encodable select value; padding bits are zero,
  // so an out-of-range select can never grant.
  localparam int unsigned SEL_SPAN = 1 << SEL_W;

  logic [SEL_SPAN-1:0] w_valid_ext;
  logic [SEL_W-1:0]    r_ptr;
  logic                w_rr_hit;
  logic [SEL_W-1:0]    w_rr_idx;
  logic [31:0]         w_cand;
  logic                w_grant;
  logic [SEL_W-1:0]    w_gidx;
  logic [WIDTH-1:0]    w_gdata;
  logic [SEL_W-1:0]    w_ptr_nxt;

  logic [WIDTH-1:0]    r_data;
  logic                r_valid;
  logic [SEL_W-1:0]    r_sel;
  logic [CNT_W-1:0]    r_cnt;

  assign w_valid_ext = SEL_SPAN'(in_valid);

  // Round-robin search: first valid channel starting at r_ptr, wrapping at CHANNELS.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = r_ptr;
    w_cand   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_cand = 32'(r_ptr) + i;
      if (w_cand >= CHANNELS) begin
        w_cand = w_cand - CHANNELS;
      end
      if (!w_rr_hit && w_valid_ext[SEL_W'(w_cand)]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = SEL_W'(w_cand);
      end
    end
  end

  // Grant decision for the current mode.
  always_comb begin
    w_grant = 1'b0;
    w_gidx  = select;
    if (mode) begin
      w_grant = w_rr_hit;
      w_gidx  = w_rr_idx;
    end else begin
      w_grant = w_valid_ext[select];
      w_gidx  = select;
    end
  end

  // Word mux for the granted channel.
  always_comb begin
    w_gdata = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (w_gidx == SEL_W'(k)) begin
        w_gdata = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer advances one past the granted channel, wrapping to 0.
  always_comb begin
    w_ptr_nxt = '0;
    if (w_gidx != SEL_W'(CHANNELS - 1)) begin
      w_ptr_nxt = SEL_W'(w_gidx + SEL_W'(1));
    end
  end

  // Round-robin pointer; only moves on a round-robin grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (mode && w_grant) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Output registers; data and index hold when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
    end else begin
      r_valid <= w_grant;
      if (w_grant) begin
        r_data <= w_gdata;
        r_sel  <= w_gidx;
      end
    end
  end

  // Saturating accepted-word counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_grant && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign out_sel    = r_sel;
  assign word_count = r_cnt;

endmodule

// File: tb/tb_mux_nx1_rr_valid.sv
// Directed + random bench for mux_nx1_rr_valid with a reference model feeding a
// scoreboard queue; explicit constant checks cover the documented scenarios.
module tb_mux_nx1_rr_valid;

  localparam int unsigned WIDTH    = 2;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned CNT_W    = 3;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      mode;
  logic [SEL_W-1:0]          select;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic [SEL_W-1:0]          out_sel;
  logic [CNT_W-1:0]          word_count;

  mux_nx1_rr_valid #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_sel(out_sel),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  // Reference model state
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic [SEL_W-1:0] m_sel;
  int               m_cnt;
  int               m_ptr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_valid = 1'b0; m_sel = '0; m_cnt = 0; m_ptr = 0;
  endtask

  // Predict the outputs after the coming edge and queue them.
  task automatic model_step();
    int g;
    exp_t e;
    g = -1;
    if (mode == 1'b0) begin
      if (int'(select) < int'(CHANNELS) && in_valid[select]) g = int'(select);
    end else begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        int c;
        c = (m_ptr + k) % int'(CHANNELS);
        if (g < 0 && in_valid[SEL_W'(c)]) g = c;
      end
    end
    if (g >= 0) begin
      m_data  = in_data[g*WIDTH +: WIDTH];
      m_sel   = SEL_W'(g);
      m_valid = 1'b1;
      if (m_cnt < CNT_MAX) m_cnt++;
      if (mode) m_ptr = (g + 1) % int'(CHANNELS);
    end else begin
      m_valid = 1'b0;
    end
    e.data = m_data; e.valid = m_valid; e.sel = m_sel; e.cnt = CNT_W'(m_cnt);
    q.push_back(e);
  endtask

  // One clock: queue prediction, advance, pop and compare.
  task automatic cyc(input string tag);
    exp_t  e;
    string t;
    model_step();
    tq.push_back(tag);
    @(posedge clk);
    #1;
    e = q.pop_front();
    t = tq.pop_front();
    chk({t, " data"},  32'(out_data),   32'(e.data));
    chk({t, " valid"}, 32'(out_valid),  32'(e.valid));
    chk({t, " sel"},   32'(out_sel),    32'(e.sel));
    chk({t, " count"}, 32'(word_count), 32'(e.cnt));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " data"},  32'(out_data),   32'h0);
    chk({tag, " valid"}, 32'(out_valid),  32'h0);
    chk({tag, " sel"},   32'(out_sel),    32'h0);
    chk({tag, " count"}, 32'(word_count), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero("reset held");
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rr[6];
    exp_rr = '{0, 1, 2, 3, 0, 1};
    reset = 1'b1; mode = 1'b0; select = '0; in_data = '0; in_valid = '0;

    // Reset and idle
    do_reset();
    for (int k = 0; k < 3; k++) cyc("idle");
    chk("idle count", 32'(word_count), 32'h0);

    // Mode 0: single word on ch2, then hold
    mode = 1'b0; select = 2'd2;
    in_data = {2'b00, 2'b11, 2'b10, 2'b01};
    in_valid = 4'b0100;
    cyc("m0 grant");
    chk("m0 grant data", 32'(out_data), 32'h3);
    chk("m0 grant sel", 32'(out_sel), 32'h2);
    chk("m0 grant valid", 32'(out_valid), 32'h1);
    in_valid = 4'b0000;
    cyc("m0 hold");
    chk("m0 hold valid", 32'(out_valid), 32'h0);
    chk("m0 hold data", 32'(out_data), 32'h3);
    chk("m0 hold count", 32'(word_count), 32'h1);
    // Selected channel not valid while others are: no grant
    select = 2'd1; in_valid = 4'b1101;
    cyc("m0 sel invalid");
    chk("m0 sel invalid valid", 32'(out_valid), 32'h0);

    // Round-robin, all valid
    do_reset();
    mode = 1'b1; in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      in_data = CHANNELS*WIDTH'($urandom);
      cyc("rr all");
      chk("rr all seq", 32'(out_sel), 32'(exp_rr[k]));
      chk("rr all valid", 32'(out_valid), 32'h1);
    end
    chk("rr all count", 32'(word_count), 32'h6);

    // Skip and wrap (ptr=2 here)
    in_valid = 4'b0100; cyc("rr to ch2");
    chk("rr to ch2 sel", 32'(out_sel), 32'h2);
    in_valid = 4'b0010; cyc("rr wrap ch1");
    chk("rr wrap ch1 sel", 32'(out_sel), 32'h1);
    in_valid = 4'b0101; cyc("rr skip ch2");
    chk("rr skip ch2 sel", 32'(out_sel), 32'h2);
    cyc("rr wrap ch0");
    chk("rr wrap ch0 sel", 32'(out_sel), 32'h0);

    // Mode 0 detour leaves ptr (=1) untouched
    mode = 1'b0; select = 2'd3; in_valid = 4'b1000; cyc("m0 detour");
    chk("m0 detour sel", 32'(out_sel), 32'h3);
    mode = 1'b1; in_valid = 4'b1111; cyc("rr resume");
    chk("rr resume sel", 32'(out_sel), 32'h1);
    in_valid = 4'b0000; cyc("rr none");
    in_valid = 4'b0100; cyc("rr after none");
    chk("rr after none sel", 32'(out_sel), 32'h2);

    // Counter saturation
    do_reset();
    mode = 1'b1; in_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      in_data = CHANNELS*WIDTH'($urandom);
      cyc("sat");
      chk("sat valid", 32'(out_valid), 32'h1);
      if (k >= 6) chk("sat count", 32'(word_count), 32'(CNT_MAX));
    end

    // Asynchronous reset mid-stream
    do_reset();
    mode = 1'b1; in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) cyc("pre async");
    #3;
    reset = 1'b1;
    #1;
    chk_zero("async reset");
    #1;
    reset = 1'b0;
    model_reset();
    cyc("post async");
    chk("post async sel", 32'(out_sel), 32'h0);
    chk("post async valid", 32'(out_valid), 32'h1);

    // Random traffic against the model
    for (int k = 0; k < 60; k++) begin
      mode     = 1'($urandom);
      select   = SEL_W'($urandom);
      in_valid = CHANNELS'($urandom);
      in_data  = CHANNELS*WIDTH'($urandom);
      cyc("rand");
    end

    chk("queue empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr_valid.md
# mux_nx1_rr_valid

Parametrised N-to-1 data multiplexer with per-channel valid qualifiers, a registered output and a round-robin mode, replacing the fixed 2:1 two-bit valid mux in the test-and-synthesis flow. Each cycle it selects one valid input word, either by an external select or by fair rotation. It registers that word with its valid flag and source index, and counts accepted words for the tester/checker pair.

## Interface
- WIDTH, 2, data bits per channel (>= 1)
- CHANNELS, 4, number of input channels (>= 2)
- SEL_W, $clog2(CHANNELS), width of select/index fields
- CNT_W, 7, width of accepted-word counter
- clk  input  1  rising-edge clock; the block has one clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- mode  input  1  0 = direct select, 1 = round-robin
- select  input  SEL_W  channel index used in mode 0
- in_data  input  CHANNELS*WIDTH  packed words; channel k at [k*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- out_data  output  WIDTH  registered selected word
- out_valid  output  1  registered valid for out_data
- out_sel  output  SEL_W  channel index that produced out_data
- word_count  output  CNT_W  number of accepted words, saturating

## Operation
- Reset values: out_data=0, out_valid=0, out_sel=0, word_count=0, internal pointer ptr=0.
- Accept means the block grants a channel g in a cycle.
- Mode 0, direct:
  - g = select when select < CHANNELS and in_valid[select]=1; otherwise no grant.
  - An out-of-range select, possible when CHANNELS is not a power of 2, never grants.
  - ptr is not modified in mode 0.
- Mode 1, round-robin:
  - Search channels in order ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1.
  - g = first channel with in_valid set.
  - On grant, ptr <= (g+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
  - With no valid channel, ptr holds.
- On grant, next edge: out_data <= word g, out_sel <= g, out_valid <= 1.
- No grant, next edge:
  - out_valid <= 0.
  - out_data and out_sel hold their last values; they are never driven to X or 0.
- word_count increments by 1 on every grant and stops at 2^CNT_W-1; it never wraps.
- A mode change takes effect on the same edge it is sampled. ptr keeps its value across mode changes, so round-robin resumes where it left off.

## Timing
- Fully synchronous except reset; all outputs are registered with no combinational input-to-output path.
- Latency is 1 cycle: inputs sampled at edge n appear on the outputs after edge n.
- Throughput is one word per cycle; there is no backpressure and no ready signal.
- Reset assertion mid-operation:
  - Outputs go to their reset values immediately, without waiting for clk.
  - The first edge after deassertion samples normally, and round-robin starts at channel 0.
- When several channels are valid in the same cycle, exactly one is granted: the select channel in mode 0, or the first from ptr in mode 1. Other valid words are dropped, not queued.
- Counter saturation and a grant in the same cycle: word_count stays at max, and the data path updates normally.

## Test plan
- Reset/idle: hold reset=1 for 2 cycles, then release with in_valid=0 for 3 cycles.
  - All outputs stay 0 and word_count stays 0.
- Mode 0 hold: WIDTH=2, CHANNELS=4, select=2, in_data ch2=2'b11, in_valid=4'b0100 for 1 cycle, then in_valid=0.
  - out_data=11, out_sel=2, out_valid=1 for one cycle.
  - Then out_valid=0 with out_data still 11; word_count=1.
- Round-robin all valid: mode=1, in_valid=4'b1111 for 6 cycles.
  - out_sel sequence 0,1,2,3,0,1 on consecutive cycles, out_valid=1 throughout, word_count=6.
- Round-robin skip and wrap: mode=1, ptr=3 reached after granting ch2, in_valid=4'b0010.
  - Grants ch1, ptr becomes 2.
  - Next cycle in_valid=4'b0101 grants ch2, then ch0.
- Saturation: CNT_W=3, in_valid=4'b1111 for 10 cycles.
  - word_count reads 7 from cycle 7 onward.
  - out_valid=1 throughout.
- Reset mid-stream: assert reset asynchronously between edges during the all-valid round-robin run.
  - Outputs are 0 before the next edge.
  - After release, the first grant is ch0.
